sysid_read_arbiter: RTL and testbench
=====================================

Name: sysid_read_arbiter

Overview:
- Round-robin read arbiter that shares one read-only, zero-latency system-ID slave (1-bit address, 32-bit readdata) between NUM_MASTERS Avalon-MM read masters.
- Sits between the masters (CPU data master, debug/boot masters) and the ID slave.
- Serialises accesses, registers the response, and returns it with a readdatavalid pulse to the granted master only.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..8)
- DATA_W, 32, readdata width
- ADDR_W, 1, slave address width

Ports:
- clock  in  1  single system clock
- reset  in  1  asynchronous, active-high reset
- m_read  in  NUM_MASTERS  per-master read request, held until accepted
- m_address  in  NUM_MASTERS*ADDR_W  per-master address, master i at slice [i*ADDR_W +: ADDR_W]
- m_waitrequest  out  NUM_MASTERS  per-master stall
- m_readdata  out  NUM_MASTERS*DATA_W  per-master read data, slice [i*DATA_W +: DATA_W]
- m_readdatavalid  out  NUM_MASTERS  per-master one-cycle data-valid pulse
- s_address  out  ADDR_W  address to the ID slave
- s_chipselect  out  1  slave access strobe
- s_readdata  in  DATA_W  slave read data, combinational on s_address

Behaviour:
- Reset values (async, immediate on reset high):
  - state=IDLE, m_waitrequest=all 1, m_readdatavalid=0, m_readdata=0, s_address=0, s_chipselect=0.
  - Round-robin pointer last_grant=NUM_MASTERS-1, so master 0 wins the first tie.
- IDLE: if any m_read is set, select the first requester strictly after last_grant (cyclic). Register grant index g and m_address[g] into s_address, then go to ISSUE. Otherwise stay in IDLE.
- ISSUE (one cycle):
  - s_chipselect=1; m_waitrequest[g]=0, all other bits stay 1.
  - At the clock edge, capture s_readdata into the response register, set last_grant=g, go to RESP.
- RESP (one cycle):
  - m_readdatavalid[g]=1; m_readdata slice g = captured data. Other slices hold their last value; readdatavalid is the qualifier.
  - If any m_read is set, arbitrate as in IDLE and go directly to ISSUE. Otherwise go to IDLE.
- Latency: m_read rising in cycle 0 gives waitrequest low in cycle 1 and readdatavalid in cycle 2. Back-to-back throughput is one read per 2 cycles.
- Fairness: with all masters requesting continuously, grants rotate 0,1,..,N-1,0. No master waits more than NUM_MASTERS grants.
- Simultaneous events:
  - A new request arriving in RESP is arbitrated in that cycle.
  - A master whose read drops while not yet granted is simply skipped; no error.
- Mid-operation reset: any in-flight transaction is dropped and no readdatavalid is issued. Masters must reissue.
- Protocol rule: a master de-asserting m_read while waitrequest is high is legal. A grant is taken only from m_read as sampled in IDLE/RESP.

Optional Feature:
- Macro: SYSID_ARB_CACHE_EN.
- When defined:
  - Add a 2^ADDR_W-entry cache with per-entry valid bits, cleared on reset.
  - On an ISSUE cycle whose address hits, s_chipselect stays 0 and the data comes from the cache. Timing is identical.
  - A miss fills the entry.
- When undefined: every ISSUE drives s_chipselect=1 and reads the slave.

Decomposition:
- Package sysid_arb_pkg:
  - state enum {IDLE, ISSUE, RESP}
  - DATA_W/ADDR_W defaults
  - function next_rr(req, last) returning the grant index
- Sub-module rr_arbiter (request vector, last_grant in, grant index/valid out) holds the combinational round-robin picker; the top holds the FSM and registers.

Test Plan:
- Single read: master 0 reads address 1 while the slave returns 0x622FA85F at addr1 and 0 at addr0. Require m_waitrequest[0]=0 in cycle 1, and m_readdatavalid[0]=1 with data 0x622FA85F in cycle 2. Require m_readdatavalid[1]=0 throughout.
- Tie from reset: masters 0 and 1 request in the same cycle, addresses 1 and 0. Require master 0 gets 0x622FA85F first, then master 1 gets 0x00000000 two cycles later.
- Continuous contention, N=4: all masters hold read for 20 grants. Require grant order 0,1,2,3,0,..., exactly 5 readdatavalid pulses per master.
- Reset mid-transaction: assert reset during ISSUE. Require all outputs at reset values immediately and no readdatavalid. After release, a reissued read completes normally with master 0 winning the tie.
- Back-to-back: master 1 holds read continuously. Require readdatavalid every 2nd cycle and s_chipselect high on alternate cycles.
- With SYSID_ARB_CACHE_EN: read addr1 twice. Require s_chipselect=1 only on the first ISSUE, identical data 0x622FA85F and identical latency both times.

Source files
------------

// File: rtl/sysid_read_arbiter_pkg.sv
// Shared types and helpers for the system-ID read arbiter: FSM state
// encoding, default bus widths and the round-robin pick function.
package sysid_arb_pkg;

  // Largest supported master count; grant indices are sized for it.
  localparam int MAX_MASTERS    = 8;
  localparam int IDX_W          = 3;
  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ADDR_W = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  // Return the first requester strictly after 'last' in cyclic order over
  // n masters. Scanning from the farthest candidate down lets the nearest
  // one overwrite the pick. With no request the result is 'last'.
  function automatic logic [IDX_W-1:0] next_rr(
    input logic [MAX_MASTERS-1:0] req,
    input logic [IDX_W-1:0]       last,
    input int                     n
  );
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] idx;
    pick = last;
    for (int k = MAX_MASTERS; k >= 1; k--) begin
      if (k <= n) begin
        idx = IDX_W'((int'(last) + k) % n);
        if (req[idx]) begin
          pick = idx;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/sysid_read_arbiter_if.sv
// Bus bundle for the system-ID read arbiter: the per-master Avalon-MM read
// ports and the single ID-slave port. The arbiter uses the slave modport;
// the masters plus ID slave (or a testbench) use the master modport.
interface sysid_read_arbiter_if
  import sysid_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int ADDR_W      = DEFAULT_ADDR_W
);

  logic [NUM_MASTERS-1:0]        m_read;
  logic [NUM_MASTERS*ADDR_W-1:0] m_address;
  logic [NUM_MASTERS-1:0]        m_waitrequest;
  logic [NUM_MASTERS*DATA_W-1:0] m_readdata;
  logic [NUM_MASTERS-1:0]        m_readdatavalid;
  logic [ADDR_W-1:0]             s_address;
  logic                          s_chipselect;
  logic [DATA_W-1:0]             s_readdata;

  modport slave (
    input  m_read,
    input  m_address,
    input  s_readdata,
    output m_waitrequest,
    output m_readdata,
    output m_readdatavalid,
    output s_address,
    output s_chipselect
  );

  modport master (
    output m_read,
    output m_address,
    output s_readdata,
    input  m_waitrequest,
    input  m_readdata,
    input  m_readdatavalid,
    input  s_address,
    input  s_chipselect
  );

endinterface

// File: rtl/sysid_read_arbiter_rr_arbiter.sv
// Combinational round-robin picker: given the request vector and the last
// granted index, returns the next master to serve and whether any request
// is pending.
module rr_arbiter
  import sysid_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       last_grant,
  output logic [IDX_W-1:0]       grant,
  output logic                   grant_valid
);

  logic [MAX_MASTERS-1:0] req_ext;

  // Pad the request vector to the fixed width the pick function expects.
  genvar gi;
  generate
    for (gi = 0; gi < MAX_MASTERS; gi++) begin : g_req
      if (gi < NUM_MASTERS) begin : g_used
        assign req_ext[gi] = req[gi];
      end else begin : g_pad
        assign req_ext[gi] = 1'b0;
      end
    end
  endgenerate

  assign grant       = next_rr(req_ext, last_grant, NUM_MASTERS);
  assign grant_valid = |req;

endmodule

// File: rtl/sysid_read_arbiter.sv
// Round-robin read arbiter sharing one zero-latency system-ID slave between
// NUM_MASTERS Avalon-MM read masters. Each access takes an ISSUE cycle
// (waitrequest low to the granted master, slave strobed) followed by a
// RESP cycle (registered data with a one-cycle readdatavalid pulse).
// Optional build macro SYSID_ARB_CACHE_EN adds a small per-address cache so
// repeat reads of an ID word skip the slave strobe with identical timing.
module sysid_read_arbiter
  import sysid_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int ADDR_W      = DEFAULT_ADDR_W
) (
  input  logic                 clock,
  input  logic                 reset,
  sysid_read_arbiter_if.slave  bus
);

  state_t                        state_reg;
  logic [IDX_W-1:0]              grant_reg;
  logic [IDX_W-1:0]              last_grant_reg;
  logic [ADDR_W-1:0]             s_address_reg;
  logic                          s_chipselect_reg;
  logic [NUM_MASTERS-1:0]        waitreq_reg;
  logic [NUM_MASTERS-1:0]        rdv_reg;
  logic [NUM_MASTERS*DATA_W-1:0] rdata_reg;

  logic [IDX_W-1:0]              pick;
  logic                          pick_valid;
  logic [ADDR_W-1:0]             pick_addr;
  logic                          pick_hit;
  logic [NUM_MASTERS-1:0]        pick_onehot;
  logic [NUM_MASTERS-1:0]        grant_onehot;
  logic [DATA_W-1:0]             issue_data;

  rr_arbiter #(
    .NUM_MASTERS (NUM_MASTERS)
  ) u_rr_arbiter (
    .req         (bus.m_read),
    .last_grant  (last_grant_reg),
    .grant       (pick),
    .grant_valid (pick_valid)
  );

  // One-hot views of the candidate grant and of the grant being served.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_onehot
      assign pick_onehot[gi]  = (pick == IDX_W'(gi));
      assign grant_onehot[gi] = (grant_reg == IDX_W'(gi));
    end
  endgenerate

  // Address of the candidate master, registered into s_address on grant.
  always_comb begin
    pick_addr = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (pick == IDX_W'(i)) begin
        pick_addr = bus.m_address[i*ADDR_W +: ADDR_W];
      end
    end
  end

`ifdef SYSID_ARB_CACHE_EN
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] cache_mem [DEPTH];
  logic [DATA_W-1:0] cache_rd_reg;
  logic [DEPTH-1:0]  cache_valid_reg;
  logic              cache_fill;

  // A strobed ISSUE cycle is always a miss, so it refills that entry.
  assign cache_fill = (state_reg == ISSUE) && s_chipselect_reg;

  // Valid bits: cleared on reset, set by each fill.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cache_valid_reg <= '0;
    end else if (cache_fill) begin
      cache_valid_reg[s_address_reg] <= 1'b1;
    end
  end

  // Cache array with registered read; the read is launched on the grant
  // edge so the word is ready for the following ISSUE edge.
  always_ff @(posedge clock) begin
    if (cache_fill) begin
      cache_mem[s_address_reg] <= bus.s_readdata;
    end
    cache_rd_reg <= cache_mem[pick_addr];
  end

  assign pick_hit   = cache_valid_reg[pick_addr];
  // chipselect low in ISSUE means the grant was a hit.
  assign issue_data = s_chipselect_reg ? bus.s_readdata : cache_rd_reg;
`else
  assign pick_hit   = 1'b0;
  assign issue_data = bus.s_readdata;
`endif

  // Arbitration FSM; every bus output is driven straight from a register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg        <= IDLE;
      grant_reg        <= '0;
      last_grant_reg   <= IDX_W'(NUM_MASTERS - 1);
      s_address_reg    <= '0;
      s_chipselect_reg <= 1'b0;
      waitreq_reg      <= '1;
      rdv_reg          <= '0;
      rdata_reg        <= '0;
    end else begin
      case (state_reg)
        IDLE, RESP: begin
          rdv_reg <= '0;
          if (pick_valid) begin
            grant_reg        <= pick;
            s_address_reg    <= pick_addr;
            s_chipselect_reg <= !pick_hit;
            waitreq_reg      <= ~pick_onehot;
            state_reg        <= ISSUE;
          end else begin
            state_reg <= IDLE;
          end
        end
        ISSUE: begin
          s_chipselect_reg <= 1'b0;
          waitreq_reg      <= '1;
          rdv_reg          <= grant_onehot;
          last_grant_reg   <= grant_reg;
          for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_reg == IDX_W'(i)) begin
              rdata_reg[i*DATA_W +: DATA_W] <= issue_data;
            end
          end
          state_reg <= RESP;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.m_waitrequest   = waitreq_reg;
  assign bus.m_readdatavalid = rdv_reg;
  assign bus.m_readdata      = rdata_reg;
  assign bus.s_address       = s_address_reg;
  assign bus.s_chipselect    = s_chipselect_reg;

endmodule

// File: tb/tb_sysid_read_arbiter.sv
// Self-checking bench for sysid_read_arbiter with four masters and a
// combinational ID slave model. Expected read data is queued per master
// when a read is issued and popped when readdatavalid is seen.
module tb_sysid_read_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 1;
  localparam logic [31:0] ID_HI = 32'h622FA85F;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  sysid_read_arbiter_if #(.NUM_MASTERS(N), .DATA_W(DW), .ADDR_W(AW)) bus ();

  // ID slave: 0x622FA85F at address 1, zero at address 0.
  assign bus.s_readdata = bus.s_address[0] ? ID_HI : 32'h0;

  sysid_read_arbiter #(
    .NUM_MASTERS (N),
    .DATA_W      (DW),
    .ADDR_W      (AW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  int          remaining   [N];
  bit          acc_pend    [N];
  logic [31:0] exp_q       [N][$];
  int          rdv_count   [N];
  int          rdv_cyc_q   [N][$];
  int          last_acc_cyc[N];
  int          last_rdv_cyc[N];
  int          order_q[$];
  int          cs_cyc_q[$];
  int          cyc = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int q_at(input int k);
    if (k < order_q.size()) return order_q[k];
    return -1;
  endfunction

  task automatic update_reads();
    for (int i = 0; i < N; i++) bus.m_read[i] = (remaining[i] > 0);
  endtask

  task automatic issue(input int m, input int a, input int n);
    bus.m_address[m*AW +: AW] = AW'(a);
    remaining[m] += n;
    for (int k = 0; k < n; k++) exp_q[m].push_back((a != 0) ? ID_HI : 32'h0);
    update_reads();
    $display("issue master=%0d addr=%0d reads=%0d cyc=%0d", m, a, n, cyc);
  endtask

  task automatic clear_state();
    for (int i = 0; i < N; i++) begin
      remaining[i] = 0;
      acc_pend[i]  = 1'b0;
      rdv_count[i] = 0;
      exp_q[i].delete();
      rdv_cyc_q[i].delete();
    end
    order_q.delete();
    cs_cyc_q.delete();
    update_reads();
  endtask

  // Advance to the next falling edge, retire reads accepted on the last
  // rising edge, then sample the DUT outputs for this cycle.
  task automatic tick();
    @(negedge clock);
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (acc_pend[i]) begin
        acc_pend[i] = 1'b0;
        if (remaining[i] > 0) remaining[i]--;
      end
    end
    update_reads();
    for (int i = 0; i < N; i++) begin
      if (!bus.m_waitrequest[i]) begin
        check($sformatf("grant_has_read_m%0d", i), 64'(bus.m_read[i]), 64'd1);
        if (bus.m_read[i]) begin
          acc_pend[i]     = 1'b1;
          last_acc_cyc[i] = cyc;
        end
      end
      if (bus.m_readdatavalid[i]) begin
        rdv_count[i]++;
        order_q.push_back(i);
        rdv_cyc_q[i].push_back(cyc);
        last_rdv_cyc[i] = cyc;
        if (exp_q[i].size() == 0) begin
          check($sformatf("unexpected_rdv_m%0d", i), 64'd1, 64'd0);
        end else begin
          check($sformatf("rdata_m%0d", i), 64'(bus.m_readdata[i*DW +: DW]),
                64'(exp_q[i].pop_front()));
        end
        $display("resp master=%0d data=0x%08h cyc=%0d", i, bus.m_readdata[i*DW +: DW], cyc);
      end
    end
    if (bus.m_readdatavalid != '0) check("rdv_onehot", 64'($countones(bus.m_readdatavalid)), 64'd1);
    if (bus.s_chipselect) cs_cyc_q.push_back(cyc);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_state();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wait"},  64'(bus.m_waitrequest),   64'hF);
    check({tag, "_rdv"},   64'(bus.m_readdatavalid), 64'h0);
    check({tag, "_cs"},    64'(bus.s_chipselect),    64'h0);
    check({tag, "_saddr"}, 64'(bus.s_address),       64'h0);
    check({tag, "_rdata"}, 64'(bus.m_readdata[63:0]), 64'h0);
  endtask

  // Hard time limit so the bench always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0;
    int c1;
    int lat1;
    int lat2;
    bus.m_read    = '0;
    bus.m_address = '0;
    clear_state();

    // Reset state.
    tick();
    check_reset_outputs("reset");
    reset = 1'b0;

    // Single read: master 0, address 1.
    c0 = cyc;
    issue(0, 1, 1);
    tick();
    check("t1_wait",  64'(bus.m_waitrequest), 64'hE);
    check("t1_cs",    64'(bus.s_chipselect),  64'h1);
    check("t1_saddr", 64'(bus.s_address),     64'h1);
    tick();
    check("t1_rdv",   64'(bus.m_readdatavalid), 64'h1);
    check("t1_data",  64'(bus.m_readdata[31:0]), 64'(ID_HI));
    repeat (3) tick();
    check("t1_acc_lat", 64'(last_acc_cyc[0] - c0), 64'd1);
    check("t1_rdv_lat", 64'(last_rdv_cyc[0] - c0), 64'd2);
    check("t1_m0_count", 64'(rdv_count[0]), 64'd1);
    check("t1_m1_count", 64'(rdv_count[1]), 64'd0);

    // Tie from reset: masters 0 and 1 together.
    do_reset();
    issue(0, 1, 1);
    issue(1, 0, 1);
    repeat (6) tick();
    check("t2_total",  64'(order_q.size()), 64'd2);
    check("t2_first",  64'(q_at(0)), 64'd0);
    check("t2_second", 64'(q_at(1)), 64'd1);
    check("t2_gap",    64'(last_rdv_cyc[1] - last_rdv_cyc[0]), 64'd2);
    check("t2_drain",  64'(exp_q[0].size() + exp_q[1].size()), 64'd0);

    // Continuous contention: four masters, five reads each.
    do_reset();
    for (int m = 0; m < N; m++) issue(m, m % 2, 5);
    repeat (50) tick();
    check("t3_total", 64'(order_q.size()), 64'd20);
    for (int k = 0; k < 20; k++) check($sformatf("t3_order%0d", k), 64'(q_at(k)), 64'(k % 4));
    for (int m = 0; m < N; m++) check($sformatf("t3_count_m%0d", m), 64'(rdv_count[m]), 64'd5);

    // Reset asserted during ISSUE.
    do_reset();
    issue(2, 1, 1);
    tick();
    check("t4_in_issue", 64'(bus.m_waitrequest), 64'hB);
    reset = 1'b1;
    #1;
    check_reset_outputs("t4_async");
    clear_state();
    tick();
    tick();
    check("t4_no_rdv", 64'(rdv_count[2]), 64'd0);
    reset = 1'b0;
    issue(2, 1, 1);
    issue(0, 1, 1);
    repeat (6) tick();
    check("t4_total",  64'(order_q.size()), 64'd2);
    check("t4_first",  64'(q_at(0)), 64'd0);
    check("t4_second", 64'(q_at(1)), 64'd2);

    // Back-to-back reads from master 1.
    do_reset();
    c0 = cyc;
    issue(1, 1, 6);
    repeat (16) tick();
    check("t5_count",    64'(rdv_count[1]), 64'd6);
    check("t5_cs_count", 64'(cs_cyc_q.size()), 64'd6);
    if (rdv_cyc_q[1].size() == 6 && cs_cyc_q.size() == 6) begin
      check("t5_first_lat", 64'(rdv_cyc_q[1][0] - c0), 64'd2);
      for (int k = 1; k < 6; k++) begin
        check($sformatf("t5_rdv_gap%0d", k), 64'(rdv_cyc_q[1][k] - rdv_cyc_q[1][k-1]), 64'd2);
        check($sformatf("t5_cs_gap%0d", k),  64'(cs_cyc_q[k] - cs_cyc_q[k-1]), 64'd2);
      end
      for (int k = 0; k < 6; k++)
        check($sformatf("t5_cs_before_rdv%0d", k), 64'(rdv_cyc_q[1][k] - cs_cyc_q[k]), 64'd1);
    end

    // Repeat read of address 1: same data and latency both times.
    do_reset();
    c0 = cyc;
    issue(0, 1, 1);
    repeat (4) tick();
    lat1 = last_rdv_cyc[0] - c0;
    c1 = cyc;
    issue(0, 1, 1);
    repeat (4) tick();
    lat2 = last_rdv_cyc[0] - c1;
    check("t6_lat1",  64'(lat1), 64'd2);
    check("t6_lat2",  64'(lat2), 64'd2);
    check("t6_count", 64'(rdv_count[0]), 64'd2);
`ifdef SYSID_ARB_CACHE_EN
    check("t6_cs_count", 64'(cs_cyc_q.size()), 64'd1);
`else
    check("t6_cs_count", 64'(cs_cyc_q.size()), 64'd2);
`endif
    check("t6_drain", 64'(exp_q[0].size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
